// File: rtl/adc_sample_packer_pkg.sv
// Shared definitions for the ADC sample packer: FSM state encoding, word
// geometry and the bit positions of the status flags in a packed word.
package adc_sample_packer_pkg;

  localparam int WORD_W           = 32;
  localparam int SAMPLE_W         = 10;
  localparam int SAMPLES_PER_WORD = 3;
  localparam int SLOT_W           = 2;
  localparam int OR_BIT           = 30;
  localparam int TRIG_BIT         = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Position a sample in its slot field of a word; other bits are zero.
  function automatic logic [WORD_W-1:0] place_sample(input logic [SLOT_W-1:0] slot,
                                                     input logic [SAMPLE_W-1:0] sample);
    logic [WORD_W-1:0] w;
    w = WORD_W'(sample) << (SAMPLE_W * int'(slot));
    return w;
  endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// Word stream from the packer to the DDR write FIFO.
//   word_o       : packed word, meaningful only while word_valid_o is high
//   word_valid_o : one-cycle strobe, one per word
//   word_full_i  : downstream FIFO full
// Handshake: this is a push-only stream. word_valid_o is never held back by
// word_full_i because the ADC cannot stall; a word strobed while
// word_full_i is high is dropped by the receiver and the master records it.
interface adc_sample_packer_if;
  import adc_sample_packer_pkg::*;

  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_full_i;

  modport master (output word_o, output word_valid_o, input word_full_i);
  modport slave  (input word_o, input word_valid_o, output word_full_i);
endinterface

// File: rtl/adc_sample_packer_word_pack.sv
// Packing datapath: slot index, word under construction (samples plus the
// accumulated over-range and slot0 trigger flags) and the output word
// register with its one-cycle valid strobe.
// Ports:
//   clear_i  : capture start, restart at slot0 with an empty word
//   take_i   : store sample_i/or_i/trig_i in the current slot this edge
//   last_i   : the sample being taken is the last of the capture
//   flush_i  : abort, emit any partial word without taking a sample
//   word_o / word_valid_o : completed word, valid the cycle after its
//                           final sample edge
module adc_word_pack
  import adc_sample_packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                take_i,
  input  logic                last_i,
  input  logic                flush_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                or_i,
  input  logic                trig_i,
  output logic [WORD_W-1:0]   word_o,
  output logic                word_valid_o
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] merged;

  always_comb begin
    // pack_q is always empty at slot0, so OR-ing in the new sample is enough.
    merged         = pack_q | place_sample(slot_q, sample_i);
    merged[OR_BIT] = pack_q[OR_BIT] | or_i;
    if (slot_q == '0) merged[TRIG_BIT] = trig_i;

    slot_d  = slot_q;
    pack_d  = pack_q;
    word_d  = word_q;
    valid_d = 1'b0;

    if (clear_i) begin
      slot_d = '0;
      pack_d = '0;
    end else if (take_i) begin
      if (slot_q == LAST_SLOT || last_i) begin
        word_d  = merged;
        valid_d = 1'b1;
        slot_d  = '0;
        pack_d  = '0;
      end else begin
        pack_d = merged;
        slot_d = slot_q + SLOT_W'(1);
      end
    end else if (flush_i && slot_q != '0) begin
      word_d  = pack_q;
      valid_d = 1'b1;
      slot_d  = '0;
      pack_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      pack_q  <= pack_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/adc_sample_packer.sv
// ADC sample packer: captures one 10-bit sample per clock while a capture
// runs, packs three per 32-bit word (bit 30 over-range, bit 31 trigger),
// stops after max_samples_i samples and flags dropped words.
// Ports:
//   clk, reset       : sample clock, async active-high reset
//   adc_data_i/adc_or_i/trig_status_i : current sample and its flags
//   capture_go_i     : level, runs a capture until capture_done_o
//   max_samples_i    : samples per capture, latched at capture start
//   wr_if            : word stream to the write FIFO (master side)
//   capture_done_o   : level, capture completed
//   overflow_o       : sticky, a word was dropped in this capture
//   sample_cnt_o     : samples taken in the current/last capture
//   state_dbg_o      : current FSM state
module adc_sample_packer
  import adc_sample_packer_pkg::*;
#(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SAMPLE_W-1:0]  adc_data_i,
  input  logic                 adc_or_i,
  input  logic                 trig_status_i,
  input  logic                 capture_go_i,
  input  logic [CNT_WIDTH-1:0] max_samples_i,
  adc_sample_packer_if.master  wr_if,
  output logic                 capture_done_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] sample_cnt_o,
  output state_t               state_dbg_o
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 last;
  logic                 take, flush, clear;
  logic [WORD_W-1:0]    word;
  logic                 word_valid;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    take    = 1'b0;
    flush   = 1'b0;
    clear   = 1'b0;
    cnt_inc = cnt_q + CNT_WIDTH'(1);
    last    = (cnt_inc == max_q);

    case (state_q)
      ST_IDLE: begin
        if (capture_go_i) begin
          if (max_samples_i != '0) begin
            max_d   = max_samples_i;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            clear   = 1'b1;
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        // Dropping go takes priority over the sample, even the last one.
        if (!capture_go_i) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          take = 1'b1;
          if (cnt_q != max_q) cnt_d = cnt_inc;
          if (last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!capture_go_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop seen on the capture-start cycle belongs to the previous capture.
    if (word_valid && wr_if.word_full_i && !clear) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      max_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  adc_word_pack u_word_pack (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .take_i       (take),
    .last_i       (last),
    .flush_i      (flush),
    .sample_i     (adc_data_i),
    .or_i         (adc_or_i),
    .trig_i       (trig_status_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign wr_if.word_o       = word;
  assign wr_if.word_valid_o = word_valid;
  assign capture_done_o     = done_q;
  assign overflow_o         = ovf_q;
  assign sample_cnt_o       = cnt_q;
  assign state_dbg_o        = state_q;

endmodule
